// File: rtl/tile_operand_loader_if.sv
// Operand-loader bus: tile/segment control from tile_compute, A/B operand
// buffer read ports, and the packed int8x4 load streams toward pe_array.
// master = loader side, slave = surrounding system side.
interface tile_operand_loader_if #(
    parameter int ADDR_BITS = 16
);
    logic                 start_tile;
    logic [15:0]          i0;
    logic [15:0]          j0;
    logic [3:0]           n_eff;
    logic [3:0]           m_eff;
    logic [15:0]          a_row_words;
    logic [15:0]          b_row_words;
    logic                 load_req;
    logic [3:0]           k_eff;

    logic                 a_rd_en;
    logic [ADDR_BITS-1:0] a_rd_addr;
    logic [31:0]          a_rd_data;
    logic                 b_rd_en;
    logic [ADDR_BITS-1:0] b_rd_addr;
    logic [31:0]          b_rd_data;

    logic                 a_ld_start;
    logic                 b_ld_start;
    logic                 a_ld_valid;
    logic [31:0]          a_ld_data;
    logic                 b_ld_valid;
    logic [31:0]          b_ld_data;
    logic                 busy;
    logic                 seg_done;
    logic                 err_proto;

    modport master (
        input  start_tile, i0, j0, n_eff, m_eff, a_row_words, b_row_words,
               load_req, k_eff, a_rd_data, b_rd_data,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               a_ld_start, b_ld_start, a_ld_valid, a_ld_data,
               b_ld_valid, b_ld_data, busy, seg_done, err_proto
    );

    modport slave (
        output start_tile, i0, j0, n_eff, m_eff, a_row_words, b_row_words,
               load_req, k_eff, a_rd_data, b_rd_data,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               a_ld_start, b_ld_start, a_ld_valid, a_ld_data,
               b_ld_valid, b_ld_data, busy, seg_done, err_proto
    );
endinterface

// File: rtl/tile_operand_loader.sv
// Tile operand loader: per load_req, reads one K-segment (8xT slice of A,
// Tx8 slice of B) from the operand buffers and streams both as int8x4 words,
// zero-padding elements outside n_eff/m_eff/k_eff.
// Optional build macro TOL_SKIP_MASKED_RD_EN: suppress buffer reads for
// words whose four bytes are all padding.
//
// state   | meaning
// S_IDLE  | waiting for load_req; accepts start_tile
// S_ISSUE | 16 read slots, one A and one B word per cycle
// S_DRAIN | last read data returns; seg_done follows
module tile_operand_loader #(
    parameter int TILE_SIZE = 8,
    parameter int SIDE      = 8,
    parameter int ADDR_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    tile_operand_loader_if.master bus
);
    localparam int         WORDS    = SIDE * TILE_SIZE / 4;
    localparam logic [3:0] LAST_CNT = 4'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_i0;
    logic [15:0] r_j0;
    logic [3:0]  r_n_eff;
    logic [3:0]  r_m_eff;
    logic [15:0] r_a_rw;
    logic [15:0] r_b_rw;
    logic [3:0]  r_k_eff;
    logic [11:0] r_seg_idx;
    logic [3:0]  r_cnt;
    logic        r_ld_start;
    logic        r_valid;
    logic [3:0]  r_a_mask;
    logic [3:0]  r_b_mask;
    logic        r_seg_done;
    logic        r_err;

    logic        w_idle;
    logic        w_issue;
    logic [3:0]  w_w;
    logic [3:0]  w_a_r;
    logic [3:0]  w_a_kk;
    logic [3:0]  w_b_kk;
    logic [3:0]  w_b_c;
    logic [3:0]  w_a_mask;
    logic [3:0]  w_b_mask;
    logic [15:0] w_a_row;
    logic [15:0] w_b_row;
    logic [15:0] w_a_prod;
    logic [15:0] w_b_prod;
    logic [15:0] w_a_addr;
    logic [15:0] w_b_addr;
    logic        w_a_rd_en;
    logic        w_b_rd_en;
    logic [31:0] w_a_out;
    logic [31:0] w_b_out;

    assign w_idle  = (r_state == S_IDLE);
    assign w_issue = (r_state == S_ISSUE);

    // Word index counts up while the slot timer counts down to its terminal value.
    assign w_w    = LAST_CNT - r_cnt;
    assign w_a_r  = {1'b0, w_w[3:1]};
    assign w_a_kk = {1'b0, w_w[0], 2'b00};
    assign w_b_kk = {1'b0, w_w[3:1]};
    assign w_b_c  = {1'b0, w_w[0], 2'b00};

    // Byte-level padding masks for the word issued in this slot.
    always_comb begin
        w_a_mask = '0;
        w_b_mask = '0;
        for (int b = 0; b < 4; b++) begin
            w_a_mask[b] = (w_a_r < r_n_eff) && ((w_a_kk + 4'(b)) < r_k_eff);
            w_b_mask[b] = (w_b_kk < r_k_eff) && ((w_b_c + 4'(b)) < r_m_eff);
        end
    end

    // Word addresses; k0 = seg_idx*TILE_SIZE, everything wraps at 16 bits.
    assign w_a_row  = r_i0 + {12'd0, w_a_r};
    assign w_a_prod = w_a_row * r_a_rw;
    assign w_a_addr = w_a_prod + 16'(r_seg_idx) * 16'(TILE_SIZE / 4) + {15'd0, w_w[0]};
    assign w_b_row  = 16'(r_seg_idx) * 16'(TILE_SIZE) + {12'd0, w_b_kk};
    assign w_b_prod = w_b_row * r_b_rw;
    assign w_b_addr = w_b_prod + {2'b00, r_j0[15:2]} + {15'd0, w_w[0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and read strobes.
    always_comb begin
        w_next    = r_state;
        w_a_rd_en = 1'b0;
        w_b_rd_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load_req) w_next = S_ISSUE;
            end
            S_ISSUE: begin
`ifdef TOL_SKIP_MASKED_RD_EN
                w_a_rd_en = |w_a_mask;
                w_b_rd_en = |w_b_mask;
`else
                w_a_rd_en = 1'b1;
                w_b_rd_en = 1'b1;
`endif
                if (r_cnt == 4'd0) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Tile latches, segment index, slot timer, stream and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i0       <= '0;
            r_j0       <= '0;
            r_n_eff    <= '0;
            r_m_eff    <= '0;
            r_a_rw     <= '0;
            r_b_rw     <= '0;
            r_k_eff    <= '0;
            r_seg_idx  <= '0;
            r_cnt      <= '0;
            r_ld_start <= 1'b0;
            r_valid    <= 1'b0;
            r_a_mask   <= '0;
            r_b_mask   <= '0;
            r_seg_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_idle && bus.start_tile) begin
                r_i0      <= bus.i0;
                r_j0      <= bus.j0;
                r_n_eff   <= bus.n_eff;
                r_m_eff   <= bus.m_eff;
                r_a_rw    <= bus.a_row_words;
                r_b_rw    <= bus.b_row_words;
                r_seg_idx <= '0;
            end else if (r_state == S_DRAIN) begin
                r_seg_idx <= r_seg_idx + 12'd1;
            end

            if (w_idle && bus.load_req) begin
                r_k_eff <= bus.k_eff;
                r_cnt   <= LAST_CNT;
            end else if (w_issue && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (!w_idle && (bus.start_tile || bus.load_req)) r_err <= 1'b1;

            r_ld_start <= w_idle && bus.load_req;
            r_valid    <= w_issue;
            r_a_mask   <= w_issue ? w_a_mask : 4'd0;
            r_b_mask   <= w_issue ? w_b_mask : 4'd0;
            r_seg_done <= (r_state == S_DRAIN);
        end
    end

    // Returned data is masked bytewise; mask is all-zero outside valid slots.
    always_comb begin
        w_a_out = '0;
        w_b_out = '0;
        for (int b = 0; b < 4; b++) begin
            w_a_out[8*b +: 8] = r_a_mask[b] ? bus.a_rd_data[8*b +: 8] : 8'h00;
            w_b_out[8*b +: 8] = r_b_mask[b] ? bus.b_rd_data[8*b +: 8] : 8'h00;
        end
    end

    assign bus.a_rd_en    = w_a_rd_en;
    assign bus.b_rd_en    = w_b_rd_en;
    assign bus.a_rd_addr  = w_issue ? ADDR_BITS'(w_a_addr) : '0;
    assign bus.b_rd_addr  = w_issue ? ADDR_BITS'(w_b_addr) : '0;
    assign bus.a_ld_start = r_ld_start;
    assign bus.b_ld_start = r_ld_start;
    assign bus.a_ld_valid = r_valid;
    assign bus.b_ld_valid = r_valid;
    assign bus.a_ld_data  = w_a_out;
    assign bus.b_ld_data  = w_b_out;
    assign bus.busy       = !w_idle;
    assign bus.seg_done   = r_seg_done;
    assign bus.err_proto  = r_err;
endmodule

// File: tb/tb_tile_operand_loader.sv
// Directed-plus-random bench for tile_operand_loader against a reference
// model of segment geometry, padding and timing.
module tb_tile_operand_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_operand_loader_if #(.ADDR_BITS(16)) bus ();

    tile_operand_loader #(.TILE_SIZE(8), .SIDE(8), .ADDR_BITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: latched tile, segment index, sticky error.
    longint m_i0, m_j0, m_arw, m_brw;
    int     m_n, m_m, m_k, m_seg;
    bit     exp_err;

    function automatic logic [31:0] hash_a(input logic [15:0] a);
        return ({16'd0, a} * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
    endfunction
    function automatic logic [31:0] hash_b(input logic [15:0] a);
        return ({16'd0, a} * 32'h85EBCA77) ^ 32'h3C3C_F00D;
    endfunction

    // Operand buffers: one-cycle read latency, garbage when not strobed.
    always @(posedge clk) begin
        bus.a_rd_data <= bus.a_rd_en ? hash_a(bus.a_rd_addr) : 32'hFFFF_FFFF;
        bus.b_rd_data <= bus.b_rd_en ? hash_b(bus.b_rd_addr) : 32'hFFFF_FFFF;
    end

    function automatic logic [15:0] ea_addr(input int w);
        longint r = w / 2, kk = 4 * (w % 2);
        return 16'(((m_i0 + r) * m_arw + (longint'(m_seg) * 8 + kk) / 4) % 65536);
    endfunction
    function automatic logic [15:0] eb_addr(input int w);
        longint kk = w / 2, c = 4 * (w % 2);
        return 16'(((longint'(m_seg) * 8 + kk) * m_brw + (m_j0 + c) / 4) % 65536);
    endfunction
    function automatic logic [3:0] ea_mask(input int w);
        logic [3:0] m;
        for (int b = 0; b < 4; b++) m[b] = (w / 2 < m_n) && (4 * (w % 2) + b < m_k);
        return m;
    endfunction
    function automatic logic [3:0] eb_mask(input int w);
        logic [3:0] m;
        for (int b = 0; b < 4; b++) m[b] = (w / 2 < m_k) && (4 * (w % 2) + b < m_m);
        return m;
    endfunction
    function automatic logic [31:0] apply(input logic [31:0] d, input logic [3:0] m);
        logic [31:0] o;
        for (int b = 0; b < 4; b++) o[8*b +: 8] = m[b] ? d[8*b +: 8] : 8'h00;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        bus.i0 = 16'($urandom); bus.j0 = 16'($urandom);
        bus.n_eff = 4'($urandom); bus.m_eff = 4'($urandom);
        bus.a_row_words = 16'($urandom); bus.b_row_words = 16'($urandom);
    endtask

    task automatic set_tile(input int i0, input int j0, input int n, input int m,
                            input int arw, input int brw);
        bus.i0 = 16'(i0); bus.j0 = 16'(j0); bus.n_eff = 4'(n); bus.m_eff = 4'(m);
        bus.a_row_words = 16'(arw); bus.b_row_words = 16'(brw);
    endtask

    task automatic latch_model();
        m_i0 = longint'(bus.i0); m_j0 = longint'(bus.j0);
        m_n = int'(bus.n_eff); m_m = int'(bus.m_eff);
        m_arw = longint'(bus.a_row_words); m_brw = longint'(bus.b_row_words);
        m_seg = 0;
    endtask

    task automatic start_only();
        bus.start_tile = 1'b1;
        latch_model();
        @(posedge clk); #1;
        bus.start_tile = 1'b0;
        scramble();
        @(negedge clk);
        chk("busy_after_start", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    // One segment; optional violation pulse at cycle viol_j, reset at cycle rst_j.
    task automatic run_segment(input int k, input bit with_start, input int viol_j, input int rst_j);
        logic        er;
        logic [31:0] d;
        bus.k_eff = 4'(k);
        bus.load_req = 1'b1;
        bus.start_tile = with_start;
        if (with_start) latch_model();
        m_k = k;
        @(posedge clk); #1;
        bus.load_req = 1'b0;
        bus.start_tile = 1'b0;
        bus.k_eff = 4'($urandom);
        if (with_start) scramble();
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            chk("a_ld_start", {31'd0, bus.a_ld_start}, {31'd0, j == 1});
            chk("b_ld_start", {31'd0, bus.b_ld_start}, {31'd0, j == 1});
            chk("busy", {31'd0, bus.busy}, {31'd0, j <= 17});
            chk("seg_done", {31'd0, bus.seg_done}, {31'd0, j == 18});
            chk("err_proto", {31'd0, bus.err_proto}, {31'd0, exp_err});
            if (j <= 16) begin
`ifdef TOL_SKIP_MASKED_RD_EN
                er = |ea_mask(j - 1);
                chk("a_rd_en", {31'd0, bus.a_rd_en}, {31'd0, er});
                er = |eb_mask(j - 1);
                chk("b_rd_en", {31'd0, bus.b_rd_en}, {31'd0, er});
`else
                chk("a_rd_en", {31'd0, bus.a_rd_en}, 32'd1);
                chk("b_rd_en", {31'd0, bus.b_rd_en}, 32'd1);
`endif
                chk("a_rd_addr", {16'd0, bus.a_rd_addr}, {16'd0, ea_addr(j - 1)});
                chk("b_rd_addr", {16'd0, bus.b_rd_addr}, {16'd0, eb_addr(j - 1)});
            end else begin
                chk("a_rd_en_idle", {31'd0, bus.a_rd_en}, 32'd0);
            end
            if (j >= 2 && j <= 17) begin
                chk("a_ld_valid", {31'd0, bus.a_ld_valid}, 32'd1);
                chk("b_ld_valid", {31'd0, bus.b_ld_valid}, 32'd1);
                d = apply(hash_a(ea_addr(j - 2)), ea_mask(j - 2));
                chk("a_ld_data", bus.a_ld_data, d);
                d = apply(hash_b(eb_addr(j - 2)), eb_mask(j - 2));
                chk("b_ld_data", bus.b_ld_data, d);
            end else begin
                chk("a_ld_valid_off", {31'd0, bus.a_ld_valid}, 32'd0);
                chk("b_ld_valid_off", {31'd0, bus.b_ld_valid}, 32'd0);
            end
            if (j == viol_j) begin
                bus.load_req = 1'b1;
                bus.start_tile = 1'b1;
                bus.k_eff = 4'($urandom);
                scramble();
            end
            if (j == rst_j) rst = 1'b1;
            @(posedge clk); #1;
            bus.load_req = 1'b0;
            bus.start_tile = 1'b0;
            if (j == viol_j) exp_err = 1'b1;
            if (j == rst_j) begin
                rst = 1'b0;
                exp_err = 1'b0;
                m_seg = 0;
                @(negedge clk);
                chk("rst_a_ld_valid", {31'd0, bus.a_ld_valid}, 32'd0);
                chk("rst_b_ld_valid", {31'd0, bus.b_ld_valid}, 32'd0);
                chk("rst_busy", {31'd0, bus.busy}, 32'd0);
                chk("rst_a_rd_en", {31'd0, bus.a_rd_en}, 32'd0);
                chk("rst_err_proto", {31'd0, bus.err_proto}, 32'd0);
                chk("rst_a_ld_data", bus.a_ld_data, 32'd0);
                @(posedge clk); #1;
                return;
            end
        end
        m_seg = (m_seg + 1) % 4096;
    endtask

    initial begin
        bus.start_tile = 1'b0;
        bus.load_req = 1'b0;
        bus.k_eff = 4'd0;
        set_tile(0, 0, 8, 8, 192, 64);
        exp_err = 1'b0;
        m_seg = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_a_rd_en", {31'd0, bus.a_rd_en}, 32'd0);
        chk("reset_b_rd_en", {31'd0, bus.b_rd_en}, 32'd0);
        chk("reset_a_ld_valid", {31'd0, bus.a_ld_valid}, 32'd0);
        chk("reset_a_ld_start", {31'd0, bus.a_ld_start}, 32'd0);
        chk("reset_seg_done", {31'd0, bus.seg_done}, 32'd0);
        chk("reset_err_proto", {31'd0, bus.err_proto}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full tile, then back-to-back segments with k_eff=5 and k_eff=8.
        set_tile(0, 0, 8, 8, 192, 64);
        start_only();
        run_segment(8, 1'b0, 0, 0);
        run_segment(5, 1'b0, 0, 0);
        run_segment(8, 1'b0, 0, 0);

        // Partial edge tile; start_tile together with load_req.
        set_tile(int'($urandom_range(3000, 0)), 4 * int'($urandom_range(200, 0)), 5, 7,
                 int'($urandom_range(300, 1)), int'($urandom_range(100, 1)));
        run_segment(8, 1'b1, 0, 0);
        run_segment(int'($urandom_range(8, 0)), 1'b0, 0, 0);

        // Degenerate extents.
        set_tile(17, 8, 0, 8, 40, 20);
        run_segment(0, 1'b1, 0, 0);
        set_tile(3, 12, 8, 0, 40, 20);
        run_segment(8, 1'b1, 0, 0);

        // Violation mid-segment: stream unaffected, err_proto sticky.
        set_tile(2, 4, 8, 8, 192, 64);
        start_only();
        run_segment(8, 1'b0, 5, 0);
        run_segment(6, 1'b0, 0, 0);

        // Random tiles with full-range addresses (exercises wrap).
        for (int t = 0; t < 5; t++) begin
            set_tile(int'($urandom_range(65535, 0)), 4 * int'($urandom_range(16383, 0)),
                     int'($urandom_range(8, 0)), int'($urandom_range(8, 0)),
                     int'($urandom_range(65535, 0)), int'($urandom_range(65535, 0)));
            run_segment(int'($urandom_range(8, 0)), 1'b1, 0, 0);
            run_segment(int'($urandom_range(8, 0)), 1'b0, 0, 0);
        end

        // Reset mid-segment, then restart from word 0.
        run_segment(8, 1'b0, 0, 8);
        set_tile(0, 0, 5, 8, 192, 64);
        run_segment(8, 1'b1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tile_operand_loader.md
Name: tile_operand_loader

Overview:
- Upstream feeder for pe_array_8x8, replacing the bench loader stub.
- On each load_req pulse from tile_compute, fetches one K-segment from the on-chip A and B operand buffers: an 8xT slice of A and a Tx8 slice of B.
- Streams both slices in parallel as packed int8x4 words on the a_ld_*/b_ld_* interface.
- Zero-pads every element outside n_eff/m_eff/k_eff, and tracks the segment index internally across one tile.

Parameters:
- TILE_SIZE, 8, K depth per segment (T); fixed at 8 in this release.
- SIDE, 8, array side; rows of A / columns of B per tile.
- ADDR_BITS, 16, operand-buffer word-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start_tile  in  1  pulse; latches i0, j0, n_eff, m_eff, a_row_words and b_row_words, and clears the segment index.
- i0  in  16  tile row origin in A.
- j0  in  16  tile column origin in B; must be a multiple of 4.
- n_eff  in  4  valid rows, 0..8.
- m_eff  in  4  valid columns, 0..8.
- a_row_words  in  16  A row stride in 32-bit words (K/4).
- b_row_words  in  16  B row stride in 32-bit words (BLOCK_M/4).
- load_req  in  1  pulse from tile_compute requesting the next segment.
- k_eff  in  4  valid k in this segment, 0..8; sampled together with load_req.
- a_rd_en  out  1  A buffer read strobe.
- a_rd_addr  out  ADDR_BITS  A buffer word address.
- a_rd_data  in  32  A buffer data, returned exactly 1 cycle after a_rd_en.
- b_rd_en  out  1  B buffer read strobe.
- b_rd_addr  out  ADDR_BITS  B buffer word address.
- b_rd_data  in  32  B buffer data, returned exactly 1 cycle after b_rd_en.
- a_ld_start  out  1  segment-start pulse to pe_array.
- b_ld_start  out  1  segment-start pulse to pe_array.
- a_ld_valid  out  1  A word valid.
- a_ld_data  out  32  A word; byte b = element b.
- b_ld_valid  out  1  B word valid.
- b_ld_data  out  32  B word; byte b = element b.
- busy  out  1  segment in flight.
- seg_done  out  1  pulse after the last word of a segment.
- err_proto  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: all outputs 0, state IDLE, seg_idx 0. Applies immediately mid-segment; streams are truncated with no further valids.
- FSM states and transitions:
  - IDLE: load_req -> ISSUE.
  - ISSUE: 16 cycles; on the 16th -> DRAIN.
  - DRAIN: 1 cycle; last data returns, then -> IDLE.
- Cycle timing, with load_req sampled at cycle t:
  - a_ld_start and b_ld_start high at t+1, busy high from t+1.
  - Read w = 0..15 issued at t+1+w.
  - Word w valid at t+2+w; valid is continuous for 16 cycles.
  - seg_done at t+18; busy low at t+18.
  - Back-to-back load_req accepted from t+18.
- Segment geometry (k0 = seg_idx*8):
  - A word w: r = w/2, kk = 4*(w%2).
  - A address = (i0+r)*a_row_words + (k0+kk)/4.
  - B word w: kk = w/2, c = 4*(w%2).
  - B address = (k0+kk)*b_row_words + (j0+c)/4.
  - All address arithmetic is modulo 2^ADDR_BITS.
- Zero-padding masks:
  - A byte b is forced to 0 when r >= n_eff or kk+b >= k_eff.
  - B byte b is forced to 0 when kk >= k_eff or c+b >= m_eff.
  - k_eff = 0, n_eff = 0 or m_eff = 0 still produce 16 words each, all zero.
- seg_idx:
  - Increments at seg_done.
  - Cleared by start_tile accepted in IDLE.
  - Wraps modulo 2^12.
- Protocol violations:
  - load_req while busy: ignored; err_proto set.
  - start_tile while busy: ignored; err_proto set.
  - start_tile and load_req in the same IDLE cycle: start_tile is applied first; the segment uses the new latched values with seg_idx 0.
  - err_proto clears only on rst.
- Tile parameters are used only as latched copies; the input ports may change after start_tile.

Optional Feature:
- Macro: TOL_SKIP_MASKED_RD_EN.
- When defined: for any word whose 4 bytes are all masked, a_rd_en/b_rd_en stays 0 for that slot. The address is still driven, and data is forced to 0. Stream timing and valid pattern are unchanged.
- When undefined: reads are issued for all 16 slots and masking is applied to the returned data.

Test Plan:
- Full tile: n=m=8, k_eff=8 on seg 0, i0=j0=0, row_words 192/64 -> 16 A words with addresses 0,1,192,193,...; B addresses 0,1,64,65,...; data matches buffers; seg_done at t+18.
- Second segment: after seg 0, a load_req with k_eff=5 -> A address (r*192)+2; A bytes for kk>=5 are 0; B rows kk 5..7 all zero; seg_idx=2 after.
- Partial edge: n=5, m=7, k_eff=8 -> A words 10..15 are all 0; byte 3 of every odd B word is 0.
- Violation: load_req at t+5 mid-segment -> stream unaffected; err_proto=1 and persists until rst.
- Reset mid-segment: rst at t+8 -> valids drop the next cycle, busy=0, seg_idx=0; a new load_req restarts at word 0.
- With TOL_SKIP_MASKED_RD_EN defined and n=5 -> a_rd_en low for A slots 10..15; output identical to the undefined build.
